// File: rtl/atomrvcore_pkg.sv
// Shared types and constants for the atomRVCORE instruction-fetch front end.
package atomrvcore_pkg;

  // Native width of PCs and instruction words.
  localparam int unsigned ATOM_XLEN = 32;

  // Default fetch PC after reset.
  localparam logic [ATOM_XLEN-1:0] ATOM_RESET_PC = 32'h0000_0000;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  // One buffered fetch result: the word and the PC it was fetched from.
  typedef struct packed {
    logic [ATOM_XLEN-1:0] pc;
    logic [ATOM_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/atomrvcore_fetch_fifo.sv
// Fetch buffer: small FIFO of {pc, instr} entries with a synchronous flush.
// The head data is forced to zero while the buffer is empty so that stale
// entries never leak onto the decode interface.
module atomrvcore_fetch_fifo
  import atomrvcore_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  output fetch_entry_t               pop_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic            pop_ok_s;
  logic            push_ok_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);

  // Pointer and occupancy update; reset and flush both empty the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_ok_s);
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok_s);
      count_q  <= count_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end
  end

  // Entry storage write.
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Head read, zeroed while empty.
  always_comb begin
    pop_data_o = '0;
    if (empty_o) begin
      pop_data_o = '0;
    end else begin
      pop_data_o = mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/atomrvcore_fetch_fifo_chk.sv
// Property checker for the fetch buffer: a push into a full buffer must be
// paired with a pop in the same cycle.
module atomrvcore_fetch_fifo_chk (
  input logic clk_i,
  input logic rst_i,
  input logic push_i,
  input logic pop_i,
  input logic full_i
);

  no_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_i && !pop_i));

endmodule

// File: rtl/atomrvcore_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues req/gnt fetches,
// buffers returned words with their PCs and handles branch redirects,
// including discarding a stale response that was in flight at redirect time.
module atomrvcore_fetch_ctrl
  import atomrvcore_pkg::*;
#(
  parameter int unsigned          DATAWIDTH  = ATOM_XLEN,
  parameter logic [DATAWIDTH-1:0] RESET_PC   = ATOM_RESET_PC,
  parameter int unsigned          FIFO_DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 redirect_i,
  input  logic [DATAWIDTH-1:0] redirect_pc_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  output logic                 instr_valid_o,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [DATAWIDTH-1:0] instr_pc_o,
  input  logic                 instr_ready_i
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_REQ   = 2'(REQ);
  localparam logic [1:0] ST_WAIT  = 2'(WAIT);
  localparam logic [1:0] ST_FLUSH = 2'(FLUSH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]           state_q, state_d;
  logic [DATAWIDTH-1:0] pc_q, pc_d;
  logic [DATAWIDTH-1:0] req_pc_q, req_pc_d;
  logic                 out_q, out_d;

  logic                 req_s;
  logic                 gnt_ok_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 flush_s;
  logic [DATAWIDTH-1:0] target_s;
  logic [1:0]           redirect_lsb_unused_s;
  logic [CW-1:0]        count_s;
  logic [CW:0]          credit_s;
  logic                 credit_ok_s;
  logic                 full_s;
  logic                 empty_s;
  fetch_entry_t         head_s;

  assign target_s              = {redirect_pc_i[DATAWIDTH-1:2], 2'b00};
  assign redirect_lsb_unused_s = redirect_pc_i[1:0];
  assign pop_s                 = ~empty_s & instr_ready_i;
  assign gnt_ok_s              = req_s & imem_gnt_i;

  // Entries left after this cycle's pop plus the one in flight must leave room.
  assign credit_s    = {1'b0, count_s} - (CW+1)'(pop_s) + (CW+1)'(out_q);
  assign credit_ok_s = (credit_s < (CW+1)'(FIFO_DEPTH));

  // Request qualification; a redirect cycle never carries a grantable request.
  always_comb begin
    req_s = 1'b0;
    if (rst_i || redirect_i) begin
      req_s = 1'b0;
    end else if (state_q == ST_REQ) begin
      req_s = credit_ok_s;
    end else if (state_q == ST_WAIT) begin
      req_s = credit_ok_s & imem_rvalid_i;
    end else begin
      req_s = 1'b0;
    end
  end

  // Next-state, fetch PC and outstanding-credit logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    out_d    = out_q;
    push_s   = 1'b0;
    flush_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_i) begin
          flush_s = 1'b1;
          pc_d    = target_s;
        end else if (gnt_ok_s) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + DATAWIDTH'(32'd4);
          out_d    = 1'b1;
          state_d  = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redirect_i) begin
          flush_s = 1'b1;
          pc_d    = target_s;
          if (imem_rvalid_i) begin
            out_d   = 1'b0;
            state_d = ST_REQ;
          end else begin
            state_d = ST_FLUSH;
          end
        end else if (imem_rvalid_i) begin
          push_s = 1'b1;
          if (gnt_ok_s) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + DATAWIDTH'(32'd4);
            out_d    = 1'b1;
            state_d  = ST_WAIT;
          end else begin
            out_d   = 1'b0;
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FLUSH: begin
        if (redirect_i) begin
          flush_s = 1'b1;
          pc_d    = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_rvalid_i) begin
          out_d   = 1'b0;
          state_d = ST_REQ;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = 1'b0;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      out_q    <= out_d;
    end
  end

  atomrvcore_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_s),
    .push_i      (push_s),
    .push_data_i ('{pc: req_pc_q, instr: imem_rdata_i}),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .count_o     (count_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  atomrvcore_fetch_fifo_chk u_fifo_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push_s),
    .pop_i  (pop_s),
    .full_i (full_s)
  );

  assign imem_req_o    = req_s;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = ~empty_s;
  assign instr_o       = head_s.instr;
  assign instr_pc_o    = head_s.pc;

endmodule
